// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - host and serial-line signal bundle for uart_core
interface uart_if;
  logic [31:0] tx_baud_modulo;
  logic [31:0] rx_baud_modulo;
  logic [7:0]  data;
  logic        wr;
  logic        txd;
  logic        tx_busy;
  logic        rxd;
  logic        rd;
  logic [7:0]  rx_data;
  logic        rx_ack;
  logic        rx_empty;
  logic        rx_perr;

  modport master (
    output tx_baud_modulo, rx_baud_modulo, data, wr, rxd, rd,
    input  txd, tx_busy, rx_data, rx_ack, rx_empty, rx_perr
  );

  modport slave (
    input  tx_baud_modulo, rx_baud_modulo, data, wr, rxd, rd,
    output txd, tx_busy, rx_data, rx_ack, rx_empty, rx_perr
  );
endinterface

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - free-running tick generator, period = baud_modulo_i + 1 clocks
module baud_gen (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] baud_modulo_i,
  output logic        baud_tick_o
);

  logic [31:0] cnt_q, cnt_d;

  // >= rather than == so a modulo lowered below the current count recovers at once
  assign baud_tick_o = (cnt_q >= baud_modulo_i);
  assign cnt_d       = baud_tick_o ? 32'd0 : cnt_q + 32'd1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= 32'd0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - UART transmitter and oversampling receiver
// Define UART_PARITY_EN to add an even-parity bit after the data bits.
module uart_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] tx_baud_modulo_i,
  input  logic [31:0] rx_baud_modulo_i,
  input  logic [7:0]  data_i,
  input  logic        wr_i,
  output logic        TxD_o,
  output logic        TX_busy_o,
  input  logic        RxD_i,
  input  logic        rd_i,
  output logic [7:0]  rx_data_o,
  output logic        RX_ack_o,
  output logic        RX_empty_o,
  output logic        RX_perr_o
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  logic tx_tick, rx_tick;

  baud_gen u_tx_baud (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .baud_modulo_i (tx_baud_modulo_i),
    .baud_tick_o   (tx_tick)
  );

  baud_gen u_rx_baud (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .baud_modulo_i (rx_baud_modulo_i),
    .baud_tick_o   (rx_tick)
  );

  uart_state_e            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0]   tx_data_q;
  logic [BIT_W-1:0]       tx_bit_q;
  logic                   tx_busy_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tx_state_q <= ST_IDLE;
    else          tx_state_q <= tx_state_d;
  end

  // Holding wr_i through the stop tick chains straight into the next start bit
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      ST_IDLE:   if (tx_busy_q && tx_tick) tx_state_d = ST_START;
      ST_START:  if (tx_tick) tx_state_d = ST_DATA;
      ST_DATA:   if (tx_tick && tx_bit_q == LAST_BIT) tx_state_d = AFTER_DATA;
      ST_PARITY: if (tx_tick) tx_state_d = ST_STOP;
      ST_STOP:   if (tx_tick) tx_state_d = wr_i ? ST_START : ST_IDLE;
      default:   tx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    TxD_o = 1'b1;
    case (tx_state_q)
      ST_START:  TxD_o = 1'b0;
      ST_DATA:   TxD_o = tx_data_q[tx_bit_q];
      ST_PARITY: TxD_o = even_parity(tx_data_q);
      default:   TxD_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_data_q <= '0;
      tx_bit_q  <= '0;
      tx_busy_q <= 1'b0;
    end else begin
      if (tx_state_q == ST_IDLE && !tx_busy_q && wr_i) begin
        tx_data_q <= data_i;
        tx_busy_q <= 1'b1;
      end
      if (tx_state_q == ST_STOP && tx_tick) begin
        if (wr_i) tx_data_q <= data_i;
        else      tx_busy_q <= 1'b0;
      end
      if (tx_state_q == ST_DATA && tx_tick) tx_bit_q <= tx_bit_q + 1'b1;
    end
  end

  assign TX_busy_o = tx_busy_q;

  logic                   rx_meta_q, rx_sync_q;
  uart_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]       rx_cnt_q;
  logic [BIT_W-1:0]       rx_bit_q;
  logic [DATA_BITS-1:0]   rx_shift_q;
  logic                   rx_ferr_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_ack_q;
  logic                   rx_empty_q;
  logic                   rx_mid;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RxD_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Half a bit after the start edge, then a full bit between later samples
  assign rx_mid = rx_tick &&
                  (rx_state_q == ST_START ? rx_cnt_q == HALF_LAST : rx_cnt_q == FULL_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rx_state_q <= ST_IDLE;
    else          rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      ST_IDLE:   if (rx_tick && !rx_sync_q) rx_state_d = ST_START;
      ST_START:  if (rx_mid) rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
      ST_DATA:   if (rx_mid && rx_bit_q == LAST_BIT) rx_state_d = AFTER_DATA;
      ST_PARITY: if (rx_mid) rx_state_d = ST_STOP;
      ST_STOP: begin
        if (rx_ferr_q) begin
          if (rx_sync_q) rx_state_d = ST_IDLE;
        end else if (rx_mid && rx_sync_q) begin
          rx_state_d = ST_IDLE;
        end
      end
      default:   rx_state_d = ST_IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  logic rx_par_q, rx_perr_q;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_ack_q   <= 1'b0;
      rx_empty_q <= 1'b1;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_ack_q <= 1'b0;
      if (rx_tick)
        rx_cnt_q <= (rx_mid || rx_state_q == ST_IDLE) ? '0 : rx_cnt_q + 1'b1;
      if (rx_state_q == ST_DATA && rx_mid) begin
        rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_q   <= rx_bit_q + 1'b1;
      end
`ifdef UART_PARITY_EN
      if (rx_state_q == ST_PARITY && rx_mid) rx_par_q <= rx_sync_q;
`endif
      if (rx_ferr_q && rx_sync_q) rx_ferr_q <= 1'b0;
      if (rd_i) rx_empty_q <= 1'b1;
      // Delivery is placed after the rd_i clear so a coincident new byte wins
      if (rx_state_q == ST_STOP && !rx_ferr_q && rx_mid) begin
        if (rx_sync_q) begin
          rx_data_q  <= rx_shift_q;
          rx_ack_q   <= 1'b1;
          rx_empty_q <= 1'b0;
`ifdef UART_PARITY_EN
          rx_perr_q  <= rx_par_q ^ even_parity(rx_shift_q);
`endif
        end else begin
          rx_ferr_q <= 1'b1;
        end
      end
    end
  end

  assign rx_data_o  = rx_data_q;
  assign RX_ack_o   = rx_ack_q;
  assign RX_empty_o = rx_empty_q;
`ifdef UART_PARITY_EN
  assign RX_perr_o  = rx_perr_q;
`else
  assign RX_perr_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - directed self-checking bench for uart_core (default build)
module tb_uart_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_if bus();

  logic loop_en = 1'b0;
  logic rxd_drv = 1'b1;
  assign bus.rxd = loop_en ? bus.txd : rxd_drv;

  uart_core #(.OVERSAMPLE(16)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .tx_baud_modulo_i (bus.tx_baud_modulo),
    .rx_baud_modulo_i (bus.rx_baud_modulo),
    .data_i           (bus.data),
    .wr_i             (bus.wr),
    .TxD_o            (bus.txd),
    .TX_busy_o        (bus.tx_busy),
    .RxD_i            (bus.rxd),
    .rd_i             (bus.rd),
    .rx_data_o        (bus.rx_data),
    .RX_ack_o         (bus.rx_ack),
    .RX_empty_o       (bus.rx_empty),
    .RX_perr_o        (bus.rx_perr)
  );

  logic t0, t3;
  baud_gen u_bg0 (.clk_i(clk), .rst_n_i(rst_n), .baud_modulo_i(32'd0), .baud_tick_o(t0));
  baud_gen u_bg3 (.clk_i(clk), .rst_n_i(rst_n), .baud_modulo_i(32'd3), .baud_tick_o(t3));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int   ack_cnt = 0;
  int   t0_cnt  = 0;
  int   t3_cnt  = 0;
  logic empty_at_ack = 1'b1;
  always @(negedge clk) begin
    if (bus.rx_ack === 1'b1) begin
      ack_cnt++;
      empty_at_ack = bus.rx_empty;
    end
    if (t0) t0_cnt++;
    if (t3) t3_cnt++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (bus.txd !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, k < 200, 1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd_drv = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (32) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (32) @(negedge clk);
  endtask

  int a0, d0, d3, k;
  logic [9:0] frame;

  initial begin
    bus.tx_baud_modulo = 32'd31;
    bus.rx_baud_modulo = 32'd1;
    bus.data = 8'h00;
    bus.wr   = 1'b0;
    bus.rd   = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_txd",      bus.txd,      1);
    check("rst_busy",     bus.tx_busy,  0);
    check("rst_rx_data",  bus.rx_data,  0);
    check("rst_ack",      bus.rx_ack,   0);
    check("rst_empty",    bus.rx_empty, 1);
    check("rst_perr",     bus.rx_perr,  0);
    rst_n = 1'b1;

    d0 = t0_cnt; d3 = t3_cnt;
    repeat (40) @(negedge clk);
    check("baud_mod0_ticks", t0_cnt - d0, 40);
    check("baud_mod3_ticks", t3_cnt - d3, 10);

    // Loopback 0xAA, with a wr_i attempt mid-frame that must be ignored
    loop_en = 1'b1;
    a0 = ack_cnt;
    bus.data = 8'hAA; bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
    check("tx_busy_set", bus.tx_busy, 1);
    wait_start("tx_start_seen");
    repeat (16) @(negedge clk);
    frame[0] = bus.txd;
    for (int i = 1; i < 10; i++) begin
      if (i == 4) begin
        bus.data = 8'h55; bus.wr = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
        repeat (31) @(negedge clk);
      end else begin
        repeat (32) @(negedge clk);
      end
      frame[i] = bus.txd;
    end
    check("tx_frame_bits", frame, 10'h354);
    repeat (40) @(negedge clk);
    check("tx_busy_clear", bus.tx_busy, 0);
    check("lb_rx_data",    bus.rx_data, 8'hAA);
    check("lb_ack_count",  ack_cnt - a0, 1);
    check("lb_empty",      bus.rx_empty, 0);
    check("lb_perr",       bus.rx_perr, 0);

    // wr_i held: start bits exactly ten bit-times apart
    a0 = ack_cnt;
    bus.data = 8'hAA; bus.wr = 1'b1;
    wait_start("b2b_first_start");
    for (int f = 0; f < 2; f++) begin
      repeat (319) @(negedge clk);
      check($sformatf("b2b_stop_%0d", f), bus.txd, 1);
      @(negedge clk);
      check($sformatf("b2b_start_%0d", f), bus.txd, 0);
    end
    bus.wr = 1'b0;
    k = 0;
    while (bus.tx_busy !== 1'b0 && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("b2b_busy_drop", k < 600, 1);
    repeat (40) @(negedge clk);
    check("b2b_ack_count", ack_cnt - a0, 3);
    check("b2b_rx_data",   bus.rx_data, 8'hAA);

    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    check("rd_sets_empty", bus.rx_empty, 1);

    // Short low glitch is rejected at the start-bit re-sample
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    a0 = ack_cnt;
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_no_ack", ack_cnt - a0, 0);
    check("glitch_empty",  bus.rx_empty, 1);

    a0 = ack_cnt;
    send_frame(8'h3C, 1'b0);
    rxd_drv = 1'b0;
    repeat (64) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (64) @(negedge clk);
    check("ferr_no_ack", ack_cnt - a0, 0);
    check("ferr_empty",  bus.rx_empty, 1);

    a0 = ack_cnt;
    send_frame(8'h3C, 1'b1);
    repeat (40) @(negedge clk);
    check("rx_3c_ack",   ack_cnt - a0, 1);
    check("rx_3c_data",  bus.rx_data, 8'h3C);
    check("rx_3c_empty", bus.rx_empty, 0);

    send_frame(8'hC3, 1'b1);
    repeat (40) @(negedge clk);
    check("overwrite_data",  bus.rx_data, 8'hC3);
    check("overwrite_empty", bus.rx_empty, 0);

    // Asynchronous reset in the middle of a looped frame
    loop_en = 1'b1;
    a0 = ack_cnt;
    bus.data = 8'h00; bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
    wait_start("rstmid_start_seen");
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_txd",     bus.txd,      1);
    check("rstmid_busy",    bus.tx_busy,  0);
    check("rstmid_empty",   bus.rx_empty, 1);
    check("rstmid_rx_data", bus.rx_data,  0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    check("rstmid_no_ack", ack_cnt - a0, 0);
    check("rstmid_idle",   bus.tx_busy, 0);

    // rd_i held across delivery: the new byte wins for that cycle
    loop_en = 1'b0;
    a0 = ack_cnt;
    bus.rd = 1'b1;
    send_frame(8'h5A, 1'b1);
    repeat (40) @(negedge clk);
    check("rdcoin_ack",         ack_cnt - a0, 1);
    check("rdcoin_empty_at_ack", empty_at_ack, 0);
    check("rdcoin_data",        bus.rx_data, 8'h5A);
    check("rdcoin_empty_after", bus.rx_empty, 1);
    bus.rd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, RX sample ticks per bit (fixed).
REQ-002 SHALL have port clk_i  in  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tx_baud_modulo_i  in  32  TX tick period minus one, in clk cycles.
REQ-005 SHALL have port rx_baud_modulo_i  in  32  RX oversample tick period minus one, in clk cycles.
REQ-006 SHALL have port data_i  in  8  byte to transmit.
REQ-007 SHALL have port wr_i  in  1  transmit request.
REQ-008 SHALL have port TxD_o  out  1  serial output.
REQ-009 SHALL have port TX_busy_o  out  1  transmitter occupied.
REQ-010 SHALL have port RxD_i  in  1  serial input, asynchronous.
REQ-011 SHALL have port rd_i  in  1  consume received byte.
REQ-012 SHALL have port rx_data_o  out  8  last received byte.
REQ-013 SHALL have port RX_ack_o  out  1  one-cycle pulse on byte received.
REQ-014 SHALL have port RX_empty_o  out  1  no unread byte held.
REQ-015 SHALL have port RX_perr_o  out  1  parity error of last frame.

Function
REQ-016 Baud counter SHALL count 0..modulo, emit a one-cycle tick when count>=modulo and wrap to 0; period = modulo+1 cycles; modulo 0 ticks every cycle.
REQ-017 Frame SHALL be: idle 1, start 0, 8 data bits LSB first, optional parity, one stop bit 1.
REQ-018 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; each bit lasts exactly one TX tick period.
REQ-019 wr_i high in IDLE SHALL latch data_i and set TX_busy_o the next cycle; START drive begins at the next TX tick.
REQ-020 wr_i while TX_busy_o=1 SHALL be ignored; the latched byte SHALL not change mid-frame.
REQ-021 TX_busy_o SHALL clear at the tick ending the stop bit; wr_i held high SHALL yield back-to-back frames with exactly one stop bit between.
REQ-022 RxD_i SHALL pass a 2-flop synchronizer before use.
REQ-023 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP, advancing on RX ticks.
REQ-024 In IDLE, a low sample on an RX tick SHALL enter START; after 8 ticks the line SHALL be re-sampled; if high (glitch) return to IDLE.
REQ-025 Data, parity and stop bits SHALL each be sampled 16 ticks after the previous sample (mid-bit).
REQ-026 Stop sampled high SHALL load rx_data_o, clear RX_empty_o and pulse RX_ack_o for one clk cycle.
REQ-027 Stop sampled low (framing error) SHALL discard the byte and return to IDLE only after the line is seen high.
REQ-028 rd_i SHALL set RX_empty_o; rd_i coincident with a new byte SHALL leave RX_empty_o=0 (new byte wins).
REQ-029 A new byte arriving while RX_empty_o=0 SHALL overwrite rx_data_o.

Reset
REQ-030 Reset SHALL force TxD_o=1, TX_busy_o=0, rx_data_o=0, RX_ack_o=0, RX_empty_o=1, RX_perr_o=0, FSMs IDLE, counters 0.
REQ-031 Reset mid-frame SHALL abort both directions immediately; no partial byte is delivered.

Configuration
REQ-032 Macro UART_PARITY_EN defined SHALL insert an even-parity bit after data on TX and check it on RX, setting RX_perr_o with RX_ack_o (byte still delivered).
REQ-033 Without UART_PARITY_EN, PARITY states SHALL be skipped and RX_perr_o tied 0.

Structure
REQ-034 A shared package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8 and OVERSAMPLE=16.
REQ-035 A sub-module baud_gen (clk_i, rst_n_i, baud_modulo_i, baud_tick_o) SHALL be instantiated twice, for TX and RX ticks.

Verification
REQ-036 tx modulo 31, rx modulo 1, TxD_o looped to RxD_i, wr_i pulsed with 0xAA -> TxD_o 0,0,1,0,1,0,1,0,1,1 at 32 cycles/bit; rx_data_o=0xAA, one RX_ack_o pulse.
REQ-037 wr_i held high with 0xAA -> continuous frames, one stop bit between, one RX_ack_o per frame.
REQ-038 modulo 0 -> tick every cycle; modulo 3 -> tick every 4th cycle.
REQ-039 RxD_i low for 4 clk cycles (rx modulo 1) -> no RX_ack_o, RX_empty_o stays 1.
REQ-040 Frame with stop=0 -> no RX_ack_o; rd_i after valid byte -> RX_empty_o=1.
REQ-041 rst_n_i low mid-frame -> TxD_o=1, TX_busy_o=0, RX_empty_o=1 immediately.
